// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the core it feeds.
package ifu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StHold
   } ifu_state_e;

   localparam logic [31:0] INST_EBREAK = 32'h00100073;
   localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
   localparam logic [31:0] RESET_PC    = 32'h80000000;

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request the word at pc, hold it until the core accepts.
// Misaligned pcs and bus errors are replaced by FAULT_INST so the core traps.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] FAULT_INST = INST_EBREAK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        inst_fault,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        rsp_err,
   output logic [31:0] fetch_cnt
);

   ifu_state_e  state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic        inst_fault_q, inst_fault_d;
   logic [31:0] cnt_q, cnt_d;

   logic        pc_misaligned;

   assign pc_misaligned = (pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         inst_q       <= 32'h0;
         inst_valid_q <= 1'b0;
         inst_fault_q <= 1'b0;
         cnt_q        <= 32'h0;
      end else begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         inst_fault_q <= inst_fault_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      inst_fault_d = inst_fault_q;
      cnt_d        = cnt_q;
      req_valid    = 1'b0;
      req_addr     = 32'h0;

      unique case (state_q)
         StIdle: begin
            state_d = StReq;
         end

         StReq: begin
            req_addr = {pc[31:2], 2'b00};
            if (pc_misaligned) begin
               // Never put a misaligned address on the bus; trap locally instead.
               inst_d       = FAULT_INST;
               inst_fault_d = 1'b1;
               inst_valid_d = 1'b1;
               state_d      = StHold;
            end else begin
               req_valid = 1'b1;
               if (req_ready) begin
                  state_d = StWait;
               end
            end
         end

         StWait: begin
            if (rsp_valid) begin
               inst_d       = rsp_err ? FAULT_INST : rsp_data;
               inst_fault_d = rsp_err;
               inst_valid_d = 1'b1;
               state_d      = StHold;
            end
         end

         StHold: begin
            if (inst_ready) begin
               // inst/inst_fault keep their value; only the valid flag drops.
               inst_valid_d = 1'b0;
               cnt_d        = cnt_q + 32'd1;
               state_d      = StReq;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign inst_fault = inst_fault_q;
   assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a scripted memory, a transaction-level reference model
// checked every cycle, and literal expectations at the interesting points.
module tb_ifu_fetch;

   localparam logic [31:0] EBREAK = 32'h00100073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = 32'h80000000;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        inst_fault;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = 32'h0;
   logic        rsp_err = 1'b0;
   logic [31:0] fetch_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   ifu_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_fault (inst_fault),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scripted memory ----------------
   int          mem_stall = 0;   // cycles req_ready stays low per request
   int          mem_lat   = 1;   // cycles after acceptance until rsp_valid
   logic [31:0] mem_data  = 32'h0;
   logic        mem_err   = 1'b0;
   bit          mem_pend;
   int          mem_wc, mem_sc;
   bit          s_acc, s_req, s_got, s_rst;

   always @(posedge clk) begin
      s_acc = req_valid && req_ready;
      s_req = req_valid;
      s_got = rsp_valid;
      s_rst = rst;
      #1;
      if (s_rst) begin
         mem_pend = 0;
         mem_wc   = 0;
         mem_sc   = 0;
      end else begin
         if (s_got) mem_pend = 0;
         if (s_acc) begin
            mem_pend = 1;
            mem_wc   = 1;
            mem_sc   = 0;
         end else begin
            if (mem_pend) mem_wc++;
            if (s_req) mem_sc++;
         end
      end
      req_ready = (mem_sc >= mem_stall);
      rsp_valid = mem_pend && (mem_wc >= mem_lat);
      rsp_data  = rsp_valid ? mem_data : 32'h0;
      rsp_err   = rsp_valid && mem_err;
   end

   // ---------------- reference model ----------------
   // started: one cycle past reset; waiting: request accepted, no data yet;
   // holding: an instruction is on offer to the core.
   bit          check_en = 0;
   bit          m_started, m_waiting, m_holding;
   logic [31:0] m_inst = 32'h0;
   logic        m_fault = 1'b0;
   logic [31:0] m_cnt = 32'h0;

   function automatic bit m_req_expected();
      return m_started && !m_waiting && !m_holding && (pc[1:0] == 2'b00);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         check_en  = 1;
         m_started = 0;
         m_waiting = 0;
         m_holding = 0;
         m_inst    = 32'h0;
         m_fault   = 1'b0;
         m_cnt     = 32'h0;
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_holding) begin
         if (inst_ready) begin
            m_cnt     = m_cnt + 32'd1;
            m_holding = 0;
         end
      end else if (m_waiting) begin
         if (rsp_valid) begin
            m_inst    = rsp_err ? EBREAK : rsp_data;
            m_fault   = rsp_err;
            m_waiting = 0;
            m_holding = 1;
         end
      end else if (pc[1:0] != 2'b00) begin
         m_inst    = EBREAK;
         m_fault   = 1'b1;
         m_holding = 1;
      end else if (req_ready) begin
         m_waiting = 1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model inst_valid", {31'h0, inst_valid}, {31'h0, m_holding});
         chk("model inst", inst, m_inst);
         chk("model inst_fault", {31'h0, inst_fault}, {31'h0, m_fault});
         chk("model fetch_cnt", fetch_cnt, m_cnt);
         chk("model req_valid", {31'h0, req_valid}, {31'h0, m_req_expected()});
         if (m_req_expected()) chk("model req_addr", req_addr, pc);
      end
   end

   // ---------------- directed sequence ----------------
   task automatic wait_valid(input string name);
      int n = 0;
      @(negedge clk);
      while (!inst_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!inst_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: inst_valid never rose, got 0 expected 1", name);
      end
   endtask

   // Called at a negedge with inst_valid high; the core takes it and moves pc.
   task automatic accept(input logic [31:0] next_pc);
      inst_ready = 1'b1;
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      pc = next_pc;
   endtask

   initial begin
      int req_cycles;
      int n;

      // Test 1: zero-wait fetch right after reset.
      mem_stall = 0;
      mem_lat   = 1;
      mem_data  = 32'h00000413;
      mem_err   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset inst", inst, 32'h0);
      chk("reset inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("reset inst_fault", {31'h0, inst_fault}, 32'h0);
      chk("reset req_valid", {31'h0, req_valid}, 32'h0);
      chk("reset req_addr", req_addr, 32'h0);
      chk("reset fetch_cnt", fetch_cnt, 32'h0);
      @(negedge clk);
      chk("c1 req_valid", {31'h0, req_valid}, 32'h1);
      chk("c1 req_addr", req_addr, 32'h80000000);
      @(negedge clk);
      chk("c2 inst_valid", {31'h0, inst_valid}, 32'h0);
      @(negedge clk);
      chk("c3 inst_valid", {31'h0, inst_valid}, 32'h1);
      chk("c3 inst", inst, 32'h00000413);
      mem_stall = 4;
      mem_lat   = 3;
      mem_data  = 32'h00a00093;
      accept(32'h80000004);
      @(negedge clk);
      chk("first accept fetch_cnt", fetch_cnt, 32'h1);

      // Test 2: request stalled 4 cycles, response 3 cycles after acceptance.
      req_cycles = 1;
      n = 0;
      while (!inst_valid && n < 40) begin
         @(negedge clk);
         n++;
         if (req_valid) req_cycles++;
      end
      chk("stall request cycles", req_cycles, 32'd5);
      chk("stall inst", inst, 32'h00a00093);
      chk("stall inst_fault", {31'h0, inst_fault}, 32'h0);
      accept(32'h80000002);

      // Test 3: misaligned pc.
      @(negedge clk);
      chk("misaligned req_valid", {31'h0, req_valid}, 32'h0);
      chk("misaligned not yet valid", {31'h0, inst_valid}, 32'h0);
      @(negedge clk);
      chk("misaligned inst_valid", {31'h0, inst_valid}, 32'h1);
      chk("misaligned inst", inst, 32'h00100073);
      chk("misaligned inst_fault", {31'h0, inst_fault}, 32'h1);
      mem_stall = 0;
      mem_lat   = 1;
      mem_data  = 32'hDEADBEEF;
      mem_err   = 1'b1;
      accept(32'h80000008);

      // Test 4: bus error replaces the data.
      wait_valid("error fetch");
      chk("error inst", inst, 32'h00100073);
      chk("error inst_fault", {31'h0, inst_fault}, 32'h1);
      chk("error fetch_cnt", fetch_cnt, 32'h3);
      mem_err  = 1'b0;
      mem_lat  = 2;
      mem_data = 32'h12345678;
      accept(32'h8000000C);

      // Test 5: reset while waiting, on the same edge as the response.
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("reset test saw rsp_valid", {31'h0, rsp_valid}, 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      pc       = 32'h80000000;
      mem_lat  = 1;
      mem_data = 32'h00000013;
      @(negedge clk);
      chk("wait reset inst", inst, 32'h0);
      chk("wait reset inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("wait reset inst_fault", {31'h0, inst_fault}, 32'h0);
      chk("wait reset fetch_cnt", fetch_cnt, 32'h0);
      chk("wait reset req_valid", {31'h0, req_valid}, 32'h0);
      @(negedge clk);
      chk("after reset req_valid", {31'h0, req_valid}, 32'h1);
      chk("after reset req_addr", req_addr, 32'h80000000);

      // Test 6: counter wrap.
      wait_valid("wrap fetch");
      chk("wrap inst", inst, 32'h00000013);
      @(posedge clk);
      #2;
      force dut.cnt_q = 32'hFFFFFFFF;
      m_cnt = 32'hFFFFFFFF;
      @(posedge clk);
      #2;
      release dut.cnt_q;
      @(negedge clk);
      chk("preloaded fetch_cnt", fetch_cnt, 32'hFFFFFFFF);
      accept(32'h80000004);
      @(negedge clk);
      chk("wrapped fetch_cnt", fetch_cnt, 32'h0);

      repeat (6) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation ran to time limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule
